// File: rtl/vc_arb_pkg.sv
// Shared definitions for the VC pop arbiter: FSM encoding and default sizing/thresholds.
package vc_arb_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int DEF_DATA_SIZE  = 10;
    localparam int DEF_DEST_BIT   = 8;
    localparam int DEF_VC0_WEIGHT = 4;
    localparam int DEF_AF         = 6;
    localparam int DEF_AE         = 1;

endpackage

// File: rtl/vc_arb_grant.sv
// Combinational eligibility and weighted VC0/VC1 grant; zero latency.
// Backpressure: a VC whose head targets an almost-full D FIFO is not eligible.
module vc_arb_grant #(
    parameter int WCNT_W     = 3,
    parameter int VC0_WEIGHT = 4
) (
    input  logic              i_en,
    input  logic              i_vc0_empty,
    input  logic              i_vc1_empty,
    input  logic              i_dest0,
    input  logic              i_dest1,
    input  logic              i_d0_afull,
    input  logic              i_d1_afull,
    input  logic [WCNT_W-1:0] i_wcnt,
    output logic              o_grant0,
    output logic              o_grant1,
    output logic              o_elig1
);

    logic w_elig0;
    logic w_elig1;

    assign w_elig0 = !i_vc0_empty && !(i_dest0 ? i_d1_afull : i_d0_afull);
    assign w_elig1 = !i_vc1_empty && !(i_dest1 ? i_d1_afull : i_d0_afull);
    assign o_elig1 = w_elig1;

    always_comb begin
        o_grant0 = 1'b0;
        o_grant1 = 1'b0;
        if (i_en) begin
            if (w_elig0 && w_elig1) begin
                // VC1 gets one forced slot once VC0 has used its full weight
                if (i_wcnt == WCNT_W'(VC0_WEIGHT)) begin
                    o_grant1 = 1'b1;
                end else begin
                    o_grant0 = 1'b1;
                end
            end else begin
                o_grant0 = w_elig0;
                o_grant1 = w_elig1;
            end
        end
    end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Pops VC0/VC1 heads and steers them to D0/D1; pop is combinational, push/data one cycle later.
// Backpressure: no pop toward an almost-full D FIFO; one word in flight at most.
module vc_pop_arbiter
    import vc_arb_pkg::*;
#(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int DEST_BIT   = DEF_DEST_BIT,
    parameter int VC0_WEIGHT = DEF_VC0_WEIGHT,
    parameter int AF_DEF     = DEF_AF,
    parameter int AE_DEF     = DEF_AE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [DATA_SIZE-1:0] afVC_i,
    input  logic [DATA_SIZE-1:0] aeVC_i,
    input  logic [DATA_SIZE-1:0] afD_i,
    input  logic [DATA_SIZE-1:0] aeD_i,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [DATA_SIZE-1:0] vc0_head,
    input  logic [DATA_SIZE-1:0] vc1_head,
    input  logic                 d0_afull,
    input  logic                 d1_afull,
    output logic [DATA_SIZE-1:0] afVC_o,
    output logic [DATA_SIZE-1:0] aeVC_o,
    output logic [DATA_SIZE-1:0] afD_o,
    output logic [DATA_SIZE-1:0] aeD_o,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 active_o
);

    localparam int WCNT_W = $clog2(VC0_WEIGHT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WCNT_W-1:0]     r_wcnt;
    logic [DATA_SIZE-1:0]  r_af_vc;
    logic [DATA_SIZE-1:0]  r_ae_vc;
    logic [DATA_SIZE-1:0]  r_af_d;
    logic [DATA_SIZE-1:0]  r_ae_d;
    logic                  r_push_d0;
    logic                  r_push_d1;
    logic [DATA_SIZE-1:0]  r_data;

    logic                  w_pop_en;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_elig1;
    logic [DATA_SIZE-1:0]  w_head;
    logic                  w_any_vc;
    logic                  w_push_pend;

    // reset gates pops so every output sits at its reset value while reset is high
    assign w_pop_en    = !reset && !init && (r_state != ST_INIT);
    assign w_any_vc    = !vc0_empty || !vc1_empty;
    assign w_push_pend = r_push_d0 || r_push_d1;
    assign w_head      = w_grant1 ? vc1_head : vc0_head;

    vc_arb_grant #(
        .WCNT_W     (WCNT_W),
        .VC0_WEIGHT (VC0_WEIGHT)
    ) u_grant (
        .i_en        (w_pop_en),
        .i_vc0_empty (vc0_empty),
        .i_vc1_empty (vc1_empty),
        .i_dest0     (vc0_head[DEST_BIT]),
        .i_dest1     (vc1_head[DEST_BIT]),
        .i_d0_afull  (d0_afull),
        .i_d1_afull  (d1_afull),
        .i_wcnt      (r_wcnt),
        .o_grant0    (w_grant0),
        .o_grant1    (w_grant1),
        .o_elig1     (w_elig1)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (init) begin
            w_state_nxt = ST_INIT;
        end else begin
            unique case (r_state)
                ST_INIT:   w_state_nxt = ST_IDLE;
                ST_IDLE:   if (w_any_vc && !(d0_afull && d1_afull)) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (!w_any_vc && !w_push_pend) w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= '0;
            r_af_vc   <= DATA_SIZE'(AF_DEF);
            r_ae_vc   <= DATA_SIZE'(AE_DEF);
            r_af_d    <= DATA_SIZE'(AF_DEF);
            r_ae_d    <= DATA_SIZE'(AE_DEF);
            r_push_d0 <= 1'b0;
            r_push_d1 <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (init) begin
                r_af_vc <= afVC_i;
                r_ae_vc <= aeVC_i;
                r_af_d  <= afD_i;
                r_ae_d  <= aeD_i;
            end
            if (w_grant1) begin
                r_wcnt <= '0;
            end else if (w_grant0 && w_elig1 && (r_wcnt != WCNT_W'(VC0_WEIGHT))) begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
            r_push_d0 <= (w_grant0 || w_grant1) && !w_head[DEST_BIT];
            r_push_d1 <= (w_grant0 || w_grant1) &&  w_head[DEST_BIT];
            if (w_grant0 || w_grant1) begin
                r_data <= w_head;
            end
        end
    end

    assign pop_vc0  = w_grant0;
    assign pop_vc1  = w_grant1;
    assign push_d0  = r_push_d0;
    assign push_d1  = r_push_d1;
    assign data_out = r_data;
    assign active_o = (r_state == ST_ACTIVE);
    assign afVC_o   = r_af_vc;
    assign aeVC_o   = r_ae_vc;
    assign afD_o    = r_af_d;
    assign aeD_o    = r_ae_d;

endmodule
